quad_decoder: RTL and testbench

Quadrature encoder front end: synchronizes and glitch-filters raw A/B encoder pins, decodes Gray-code transitions into single-cycle count-up/count-down strobes, and flags illegal double-bit transitions. Sits directly upstream of the generic up/down counter: `cu`/`cd` connect straight to the counter's `cu`/`cd` inputs, sharing the same `clk`, `rst` and `ce`.

---
 rtl/quad_decoder.sv | 153 +++++++++++++++
 tb/tb_quad_decoder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/quad_decoder.sv
// Quadrature encoder front end: synchronizes and glitch-filters the raw A/B pins,
// then decodes Gray-code steps into one-cycle count-up/count-down/error strobes.
module quad_decoder #(
    parameter int         SYNC_STAGES = 2,
    parameter int         FILT        = 4,
    parameter logic [1:0] MODE        = 2'd0
) (
    input  logic       rst,
    input  logic       clk,
    input  logic       ce,
    input  logic       a,
    input  logic       b,
    input  logic       err_clr,
    output logic       cu,
    output logic       cd,
    output logic       dir,
    output logic       err,
    output logic       err_flag,
    output logic [1:0] ab
);

    localparam int PW = $clog2(SYNC_STAGES + 1);

    typedef enum logic {PRIME, RUN} state_t;

    state_t                 state, state_nxt;
    logic [PW-1:0]          prime_cnt, prime_nxt;
    logic [SYNC_STAGES-1:0] sa, sb;
    logic [1:0]             sync;
    logic [1:0]             prev;
    logic [7:0]             fcnt [2];

    logic one_bit, two_bit, a_chg, fwd, rev, up, dn;

    // Synchronizers run every clk; ce does not gate them.
    always_ff @(posedge clk) begin
        if (rst) begin
            sa <= '0;
            sb <= '0;
        end else begin
            sa <= {sa[SYNC_STAGES-2:0], a};
            sb <= {sb[SYNC_STAGES-2:0], b};
        end
    end

    assign sync = {sa[SYNC_STAGES-1], sb[SYNC_STAGES-1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= PRIME;
            prime_cnt <= '0;
        end else begin
            state     <= state_nxt;
            prime_cnt <= prime_nxt;
        end
    end

    // PRIME lets the synchronizer flush before decoding starts, so whatever level
    // the pins sit at after reset is adopted without producing a count or error.
    always_comb begin
        state_nxt = state;
        prime_nxt = prime_cnt;
        case (state)
            PRIME: begin
                prime_nxt = prime_cnt + PW'(1);
                if (prime_cnt == PW'(SYNC_STAGES))
                    state_nxt = RUN;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // Step classification: prev is the last decoded state, ab the current one.
    always_comb begin
        one_bit = (prev ^ ab) == 2'b01 || (prev ^ ab) == 2'b10;
        two_bit = (prev ^ ab) == 2'b11;
        a_chg   = prev[1] != ab[1];
        fwd     = (prev == 2'b00 && ab == 2'b10) || (prev == 2'b10 && ab == 2'b11) ||
                  (prev == 2'b11 && ab == 2'b01) || (prev == 2'b01 && ab == 2'b00);
        rev     = one_bit && !fwd;
        up      = 1'b0;
        dn      = 1'b0;
        case (MODE)
            2'd1: begin
                up = fwd && a_chg;
                dn = rev && a_chg;
            end
            2'd2: begin
                up = prev == 2'b00 && ab == 2'b10;
                dn = prev == 2'b10 && ab == 2'b00;
            end
            default: begin
                up = fwd;
                dn = rev;
            end
        endcase
    end

    // Strobes are registered and default low every clk, so they are one clk wide
    // and forced low whenever ce is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            ab       <= 2'b00;
            prev     <= 2'b00;
            fcnt[0]  <= 8'd0;
            fcnt[1]  <= 8'd0;
            cu       <= 1'b0;
            cd       <= 1'b0;
            err      <= 1'b0;
            err_flag <= 1'b0;
            dir      <= 1'b1;
        end else begin
            cu  <= 1'b0;
            cd  <= 1'b0;
            err <= 1'b0;
            if (state == PRIME) begin
                ab      <= sync;
                prev    <= sync;
                fcnt[0] <= 8'd0;
                fcnt[1] <= 8'd0;
            end else if (ce) begin
                for (int i = 0; i < 2; i++) begin
                    if (sync[i] != ab[i]) begin
                        if (fcnt[i] == 8'(FILT - 1)) begin
                            ab[i]   <= sync[i];
                            fcnt[i] <= 8'd0;
                        end else begin
                            fcnt[i] <= fcnt[i] + 8'd1;
                        end
                    end else begin
                        fcnt[i] <= 8'd0;
                    end
                end
                prev <= ab;
                cu   <= up;
                cd   <= dn;
                err  <= two_bit;
                if (one_bit)
                    dir <= fwd;
            end
            // A new error wins over a simultaneous clear.
            if (ce) begin
                if (state == RUN && two_bit)
                    err_flag <= 1'b1;
                else if (err_clr)
                    err_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: x4, x2 and x1 instances share one set of pins; a monitor
// pops expected strobe codes from per-instance queues as each strobe appears.
module tb_quad_decoder;

  localparam logic [2:0] CU = 3'b100;
  localparam logic [2:0] CD = 3'b010;
  localparam logic [2:0] ER = 3'b001;
  localparam logic [2:0] NO = 3'b000;

  logic       clk = 1'b0;
  logic       rst, ce, a, b, err_clr;
  logic       cu_v [3];
  logic       cd_v [3];
  logic       dir_v [3];
  logic       err_v [3];
  logic       ef_v [3];
  logic [1:0] ab_v [3];

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic ce_q = 1'b1;
  logic ce_div = 1'b0;
  int   ev_cyc [3];
  int   cu_cnt [3];
  int   cd_cnt [3];
  int   updn = 0;

  logic [2:0] exp_q0[$];
  logic [2:0] exp_q1[$];
  logic [2:0] exp_q2[$];

  quad_decoder #(.SYNC_STAGES(2), .FILT(4), .MODE(2'd0)) dut_x4 (
    .rst(rst), .clk(clk), .ce(ce), .a(a), .b(b), .err_clr(err_clr),
    .cu(cu_v[0]), .cd(cd_v[0]), .dir(dir_v[0]), .err(err_v[0]),
    .err_flag(ef_v[0]), .ab(ab_v[0]));
  quad_decoder #(.SYNC_STAGES(2), .FILT(4), .MODE(2'd1)) dut_x2 (
    .rst(rst), .clk(clk), .ce(ce), .a(a), .b(b), .err_clr(err_clr),
    .cu(cu_v[1]), .cd(cd_v[1]), .dir(dir_v[1]), .err(err_v[1]),
    .err_flag(ef_v[1]), .ab(ab_v[1]));
  quad_decoder #(.SYNC_STAGES(2), .FILT(4), .MODE(2'd2)) dut_x1 (
    .rst(rst), .clk(clk), .ce(ce), .a(a), .b(b), .err_clr(err_clr),
    .cu(cu_v[2]), .cd(cd_v[2]), .dir(dir_v[2]), .err(err_v[2]),
    .err_flag(ef_v[2]), .ab(ab_v[2]));

  // Clock and cycle bookkeeping
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    ce_q <= ce;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [2:0] act;
    logic [2:0] exp_v;
    logic       have;
    for (int i = 0; i < 3; i++) begin
      act = {cu_v[i], cd_v[i], err_v[i]};
      if (act != 3'b000) begin
        ev_cyc[i] = cyc;
        if (cu_v[i]) cu_cnt[i]++;
        if (cd_v[i]) cd_cnt[i]++;
        if (i == 0) updn = updn + int'(cu_v[0]) - int'(cd_v[0]);
        check($sformatf("strobe_on_ce_clk_%0d", i), 32'(ce_q), 32'd1);
        have = 1'b0;
        exp_v = NO;
        case (i)
          0: if (exp_q0.size() > 0) begin exp_v = exp_q0.pop_front(); have = 1'b1; end
          1: if (exp_q1.size() > 0) begin exp_v = exp_q1.pop_front(); have = 1'b1; end
          default: if (exp_q2.size() > 0) begin exp_v = exp_q2.pop_front(); have = 1'b1; end
        endcase
        if (!have)
          check($sformatf("unexpected_strobe_%0d", i), 32'(act), 32'(NO));
        else
          check($sformatf("strobe_code_%0d", i), 32'(act), 32'(exp_v));
      end
    end
  end

  // Driver: apply a new pin state, queue expected codes, hold for some clks.
  task automatic step(input logic [1:0] v, input logic [2:0] e4, input logic [2:0] e2,
                      input logic [2:0] e1, input int hold);
    a = v[1];
    b = v[0];
    if (e4 != NO) exp_q0.push_back(e4);
    if (e2 != NO) exp_q1.push_back(e2);
    if (e1 != NO) exp_q2.push_back(e1);
    repeat (hold) begin
      @(negedge clk);
      ce = ce_div ? (cyc % 4 == 0) : 1'b1;
    end
  endtask

  task automatic check_all(input string name, input int sel, input logic [1:0] exp_v);
    for (int i = 0; i < 3; i++) begin
      case (sel)
        0: check($sformatf("%s_%0d", name, i), 32'(dir_v[i]), 32'(exp_v));
        1: check($sformatf("%s_%0d", name, i), 32'(ef_v[i]), 32'(exp_v));
        default: check($sformatf("%s_%0d", name, i), 32'(ab_v[i]), 32'(exp_v));
      endcase
    end
  endtask

  initial begin
    int t0, snap_updn, snap_cd0, snap_cd1, snap_cd2, snap_cu0, snap_cu1, snap_cu2;
    for (int i = 0; i < 3; i++) begin
      ev_cyc[i] = 0; cu_cnt[i] = 0; cd_cnt[i] = 0;
    end
    rst = 1'b1; ce = 1'b1; a = 1'b1; b = 1'b1; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_strobes_%0d", i), 32'({cu_v[i], cd_v[i], err_v[i]}), 32'd0);
    end
    check_all("rst_err_flag", 1, 2'b0);
    check_all("rst_dir", 0, 2'b1);
    check_all("rst_ab", 2, 2'b00);

    // Priming with both pins high
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_all("prime_ab_edge2", 2, 2'b00);
    @(negedge clk);
    #1;
    check_all("prime_ab_edge3", 2, 2'b11);
    repeat (10) @(negedge clk);
    check_all("prime_err_flag", 1, 2'b0);

    // Walk forward to 00
    step(2'b01, CU, CU, NO, 8);
    step(2'b00, CU, NO, NO, 8);

    // x4 forward cycle with first-pulse latency
    snap_updn = updn; snap_cu0 = cu_cnt[0]; snap_cd0 = cd_cnt[0];
    t0 = cyc;
    step(2'b10, CU, CU, CU, 8);
    check("first_cu_latency", 32'(ev_cyc[0] - t0), 32'd7);
    step(2'b11, CU, NO, NO, 8);
    step(2'b01, CU, CU, NO, 8);
    step(2'b00, CU, NO, NO, 8);
    check("fwd_cu_count", 32'(cu_cnt[0] - snap_cu0), 32'd4);
    check("fwd_no_cd", 32'(cd_cnt[0] - snap_cd0), 32'd0);
    check("fwd_updn", 32'(updn - snap_updn), 32'd4);
    check_all("fwd_dir", 0, 2'b1);

    // Two reverse cycles
    snap_cd0 = cd_cnt[0]; snap_cd1 = cd_cnt[1]; snap_cd2 = cd_cnt[2];
    for (int k = 0; k < 2; k++) begin
      step(2'b01, CD, NO, NO, 8);
      step(2'b11, CD, CD, NO, 8);
      step(2'b10, CD, NO, NO, 8);
      step(2'b00, CD, CD, CD, 8);
    end
    check("rev_cd_x4", 32'(cd_cnt[0] - snap_cd0), 32'd8);
    check("rev_cd_x2", 32'(cd_cnt[1] - snap_cd1), 32'd4);
    check("rev_cd_x1", 32'(cd_cnt[2] - snap_cd2), 32'd2);
    check_all("rev_dir", 0, 2'b0);

    // Glitch of 3 clks is rejected
    a = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      #1;
      if (k == 2) a = 1'b0;
      check("glitch3_ab", 32'(ab_v[0]), 32'd0);
    end

    // Pulse of 4 clks is accepted, then its falling edge counts back down
    snap_cu0 = cu_cnt[0];
    exp_q0.push_back(CU); exp_q1.push_back(CU); exp_q2.push_back(CU);
    exp_q0.push_back(CD); exp_q1.push_back(CD); exp_q2.push_back(CD);
    a = 1'b1;
    repeat (4) @(negedge clk);
    a = 1'b0;
    repeat (16) @(negedge clk);
    check("pulse4_cu", 32'(cu_cnt[0] - snap_cu0), 32'd1);
    check_all("pulse4_ab", 2, 2'b00);

    // Illegal 00 -> 11
    step(2'b11, ER, ER, ER, 8);
    check_all("illegal_flag", 1, 2'b1);
    check_all("illegal_dir", 0, 2'b0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #1;
    check_all("clear_flag", 1, 2'b0);

    // Clear coinciding with a new error: set wins
    t0 = cyc;
    a = 1'b0; b = 1'b0;
    exp_q0.push_back(ER); exp_q1.push_back(ER); exp_q2.push_back(ER);
    repeat (6) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #1;
    check("clr_vs_err_align", 32'(ev_cyc[0] - t0), 32'd7);
    check_all("clr_vs_err_flag", 1, 2'b1);
    repeat (4) @(negedge clk);

    // ce duty-cycled 1 in 4 during a forward cycle
    snap_updn = updn; snap_cu1 = cu_cnt[1]; snap_cu2 = cu_cnt[2];
    ce_div = 1'b1;
    step(2'b10, CU, CU, CU, 32);
    step(2'b11, CU, NO, NO, 32);
    step(2'b01, CU, CU, NO, 32);
    step(2'b00, CU, NO, NO, 32);
    ce_div = 1'b0;
    ce = 1'b1;
    repeat (4) @(negedge clk);
    check("ce_updn", 32'(updn - snap_updn), 32'd4);
    check("ce_cu_x2", 32'(cu_cnt[1] - snap_cu1), 32'd2);
    check("ce_cu_x1", 32'(cu_cnt[2] - snap_cu2), 32'd1);
    check_all("ce_dir", 0, 2'b1);

    // Every queued strobe must have appeared
    check("left_in_q0", 32'(exp_q0.size()), 32'd0);
    check("left_in_q1", 32'(exp_q1.size()), 32'd0);
    check("left_in_q2", 32'(exp_q2.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
